// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_multi
// Brief    : SPI master with runtime CPOL/CPHA, programmable SCLK divider,
//            MSB/LSB-first shifting, DATA_W-bit frames and NUM_CS one-hot
//            active-low chip selects behind a start/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          ready,
    input  logic                                          cpol,
    input  logic                                          cpha,
    input  logic                                          lsb_first,
    input  logic [DIV_W-1:0]                              clk_div,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic [DATA_W-1:0]                             tx_data,
    output logic [DATA_W-1:0]                             rx_data,
    output logic                                          rx_valid,
    output logic                                          spi_sclk,
    output logic                                          spi_mosi,
    input  logic                                          spi_miso,
    output logic [NUM_CS-1:0]                             spi_cs_n
);

    localparam int c_BIT_W = $clog2(DATA_W);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_LEAD  = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [c_BIT_W-1:0] r_bit;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic [DATA_W-1:0]  r_tx_sh;
    logic [DATA_W-1:0]  r_rx_sh;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_sclk;
    logic               r_mosi;
    logic [NUM_CS-1:0]  r_cs_n;

    logic               w_phase_end;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic               w_last_bit;
    logic               w_tx_bit;
    logic [DATA_W-1:0]  w_tx_shift;
    logic [DATA_W-1:0]  w_rx_shift;
    logic [NUM_CS-1:0]  w_cs_n_sel;

    // Each SETUP/LEAD/TRAIL/HOLD phase lasts clk_div+1 cycles
    assign w_phase_end = (r_cnt == r_div);
    assign w_cnt_nxt   = w_phase_end ? '0 : r_cnt + DIV_W'(1);
    assign w_last_bit  = (r_bit == c_BIT_W'(DATA_W - 1));

    // Next outgoing bit and the shift that consumes it, in the latched bit order
    assign w_tx_bit    = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_W-1];
    assign w_tx_shift  = r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
    // MSB-first frames enter at bit 0, LSB-first frames at the top bit
    assign w_rx_shift  = r_lsb ? {spi_miso, r_rx_sh[DATA_W-1:1]}
                               : {r_rx_sh[DATA_W-2:0], spi_miso};

    assign ready    = (r_state == c_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

    // Decode cs_sel to one active-low line; out-of-range indices select nothing
    always_comb begin
        w_cs_n_sel = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                w_cs_n_sel[i] = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: SETUP, DATA_W LEAD/TRAIL pairs, HOLD, one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)       w_state_nxt = c_SETUP;
            c_SETUP: if (w_phase_end) w_state_nxt = c_LEAD;
            c_LEAD:  if (w_phase_end) w_state_nxt = c_TRAIL;
            c_TRAIL: if (w_phase_end) w_state_nxt = w_last_bit ? c_HOLD : c_LEAD;
            c_HOLD:  if (w_phase_end) w_state_nxt = c_DONE;
            c_DONE:                   w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: config latch, divider, SCLK/MOSI generation, MISO capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_rx_valid <= 1'b0;

            if ((r_state == c_IDLE) || (r_state == c_DONE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
            end

            case (r_state)
                c_IDLE: begin
                    r_sclk <= cpol;
                    r_bit  <= '0;
                    if (start) begin
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_lsb   <= lsb_first;
                        r_div   <= clk_div;
                        r_cs_n  <= w_cs_n_sel;
                        r_rx_sh <= '0;
                        // CPHA=0 needs the first bit valid before the first edge
                        if (!cpha) begin
                            r_mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                            r_tx_sh <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
                        end else begin
                            r_tx_sh <= tx_data;
                        end
                    end
                end
                c_LEAD: begin
                    if (w_phase_end) begin
                        r_sclk <= ~r_cpol;
                        if (!r_cpha) begin
                            r_rx_sh <= w_rx_shift;
                        end else begin
                            r_mosi  <= w_tx_bit;
                            r_tx_sh <= w_tx_shift;
                        end
                    end
                end
                c_TRAIL: begin
                    if (w_phase_end) begin
                        r_sclk <= r_cpol;
                        if (r_cpha) begin
                            r_rx_sh <= w_rx_shift;
                        end else if (!w_last_bit) begin
                            r_mosi  <= w_tx_bit;
                            r_tx_sh <= w_tx_shift;
                        end
                        if (!w_last_bit) begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end
                end
                c_HOLD: begin
                    if (w_phase_end) begin
                        r_cs_n     <= '1;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_multi
// Brief    : Directed self-checking bench for spi_master_multi: SPI modes,
//            bit order, handshake, abort, back-to-back and invalid cs_sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] clk_div;
    logic [1:0] cs_sel;
    logic [7:0] tx_data;
    logic       ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] spi_cs_n;

    // second instance with five selects so an out-of-range index is encodable
    logic       b_start;
    logic [2:0] b_cs_sel;
    logic [7:0] b_tx_data;
    logic       b_ready;
    logic [7:0] b_rx_data;
    logic       b_rx_valid;
    logic       b_sclk;
    logic       b_mosi;
    logic [4:0] b_cs_n;

    int n_checks = 0;
    int n_errors = 0;

    // slave model state
    logic       loopback = 1'b1;
    logic       sl_cpol = 1'b0;
    logic       sl_cpha = 1'b0;
    logic       sl_lsb = 1'b0;
    logic [7:0] sl_tx = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    logic [7:0] sl_seq = 8'h00;
    logic       sl_miso = 1'b0;
    logic       sl_act;
    logic       sl_prev_act = 1'b0;
    logic       sl_prev_sclk = 1'b0;
    int         sl_out_idx = 0;
    int         sl_in_idx = 0;

    // frame results
    bit         f_got;
    int         f_lat;
    logic [7:0] f_rx;
    int         f_rises;
    int         f_togs;
    logic [3:0] f_cs_and;
    logic [3:0] f_cs_or;
    bit         f_mosi_bad;
    bit         f_rdy_bad;

    assign spi_miso = loopback ? spi_mosi : sl_miso;

    always #5 clk = ~clk;

    spi_master_multi #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .cs_sel(cs_sel), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    spi_master_multi #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .ready(b_ready),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .cs_sel(b_cs_sel), .tx_data(b_tx_data), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_mosi), .spi_cs_n(b_cs_n)
    );

    function automatic logic sl_bit(input int k);
        if (k > 7) return 1'b0;
        return sl_lsb ? sl_tx[k] : sl_tx[7-k];
    endfunction

    // behavioural SPI slave: shifts out sl_tx, captures MOSI into sl_rx/sl_seq
    always @(negedge clk) begin
        sl_act = (spi_cs_n != 4'hF);
        if (sl_act && !sl_prev_act) begin
            sl_out_idx = 0;
            sl_in_idx  = 0;
            sl_rx      = 8'h00;
            sl_seq     = 8'h00;
            if (!sl_cpha) sl_miso = sl_bit(0);
        end else if (sl_act && (spi_sclk != sl_prev_sclk)) begin
            if (spi_sclk != sl_cpol) begin
                if (!sl_cpha) begin
                    if (sl_in_idx < 8) begin
                        sl_seq[sl_in_idx] = spi_mosi;
                        if (sl_lsb) sl_rx[sl_in_idx] = spi_mosi; else sl_rx[7-sl_in_idx] = spi_mosi;
                        sl_in_idx++;
                    end
                end else begin
                    sl_miso = sl_bit(sl_out_idx);
                    sl_out_idx++;
                end
            end else begin
                if (!sl_cpha) begin
                    sl_out_idx++;
                    sl_miso = sl_bit(sl_out_idx);
                end else if (sl_in_idx < 8) begin
                    sl_seq[sl_in_idx] = spi_mosi;
                    if (sl_lsb) sl_rx[sl_in_idx] = spi_mosi; else sl_rx[7-sl_in_idx] = spi_mosi;
                    sl_in_idx++;
                end
            end
        end
        sl_prev_act  = sl_act;
        sl_prev_sclk = spi_sclk;
    end

    // drives one frame on dut and records what was observed (no comparisons here)
    task automatic do_frame(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                            input logic [7:0] p_div, input logic [1:0] p_sel,
                            input logic [7:0] p_tx, input int poke);
        logic prev_sclk;
        logic prev_mosi;
        f_got = 1'b0; f_lat = 0; f_rx = 8'h00; f_rises = 0; f_togs = 0;
        f_cs_and = 4'hF; f_cs_or = 4'h0; f_mosi_bad = 1'b0; f_rdy_bad = 1'b0;
        @(negedge clk);
        cpol = p_cpol; cpha = p_cpha; lsb_first = p_lsb; clk_div = p_div;
        cs_sel = p_sel; tx_data = p_tx; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
        f_cs_and = f_cs_and & spi_cs_n;
        f_cs_or  = f_cs_or | spi_cs_n;
        if (ready !== 1'b0) f_rdy_bad = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready !== 1'b0) f_rdy_bad = 1'b1;
            if (rx_valid === 1'b1) begin
                f_got = 1'b1; f_lat = k; f_rx = rx_data;
                break;
            end
            f_cs_and = f_cs_and & spi_cs_n;
            f_cs_or  = f_cs_or | spi_cs_n;
            if (spi_sclk !== prev_sclk) begin
                f_togs++;
                if (spi_sclk === 1'b1) f_rises++;
            end
            if ((spi_mosi !== prev_mosi) && !(prev_sclk === 1'b1 && spi_sclk === 1'b0))
                f_mosi_bad = 1'b1;
            prev_sclk = spi_sclk;
            prev_mosi = spi_mosi;
            if (k == poke) begin
                start = 1'b1; tx_data = ~tx_data; cpol = ~cpol; cpha = ~cpha;
                lsb_first = ~lsb_first; clk_div = 8'h00; cs_sel = cs_sel + 2'd1;
            end
            if (k == poke + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; b_start = 1'b0; cpol = 1'b1; cpha = 1'b0;
        lsb_first = 1'b0; clk_div = 8'h00; cs_sel = 2'd0; tx_data = 8'h00;
        b_cs_sel = 3'd0; b_tx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (spi_sclk !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
        n_checks++; if (spi_mosi !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
        n_checks++; if (spi_cs_n !== 4'hF) begin n_errors++; $display("FAIL reset_cs_n: got %b expected 1111", spi_cs_n); end
        n_checks++; if (b_cs_n !== 5'h1F) begin n_errors++; $display("FAIL reset_cs_n_b: got %b expected 11111", b_cs_n); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        loopback = 1'b1;
        do_frame(1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 8'hA5, -1);
        n_checks++; if (f_got !== 1'b1) begin n_errors++; $display("FAIL m0_rx_valid: got %b expected 1", f_got); end
        n_checks++; if (f_lat != 18) begin n_errors++; $display("FAIL m0_latency: got %0d expected 18", f_lat); end
        n_checks++; if (f_rx !== 8'hA5) begin n_errors++; $display("FAIL m0_rx_data: got %h expected a5", f_rx); end
        n_checks++; if (f_rises != 8) begin n_errors++; $display("FAIL m0_rises: got %0d expected 8", f_rises); end
        n_checks++; if (f_togs != 16) begin n_errors++; $display("FAIL m0_toggles: got %0d expected 16", f_togs); end
        n_checks++; if (f_cs_and !== 4'b1011) begin n_errors++; $display("FAIL m0_cs_and: got %b expected 1011", f_cs_and); end
        n_checks++; if (f_cs_or !== 4'b1011) begin n_errors++; $display("FAIL m0_cs_or: got %b expected 1011", f_cs_or); end
        n_checks++; if (f_rdy_bad !== 1'b0) begin n_errors++; $display("FAIL m0_ready_busy: got %b expected 0", f_rdy_bad); end
        n_checks++; if (spi_cs_n !== 4'hF) begin n_errors++; $display("FAIL m0_cs_done: got %b expected 1111", spi_cs_n); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL m0_ready_after: got %b expected 1", ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL m0_pulse_width: got %b expected 0", rx_valid); end
    endtask

    task automatic test_mode3_slave();
        loopback = 1'b0; sl_cpol = 1'b1; sl_cpha = 1'b1; sl_lsb = 1'b0; sl_tx = 8'hC3;
        @(negedge clk);
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (spi_sclk !== 1'b1) begin n_errors++; $display("FAIL m3_idle_sclk: got %b expected 1", spi_sclk); end
        do_frame(1'b1, 1'b1, 1'b0, 8'd3, 2'd0, 8'h3C, -1);
        n_checks++; if (f_got !== 1'b1) begin n_errors++; $display("FAIL m3_rx_valid: got %b expected 1", f_got); end
        n_checks++; if (f_lat != 72) begin n_errors++; $display("FAIL m3_latency: got %0d expected 72", f_lat); end
        n_checks++; if (f_rx !== 8'hC3) begin n_errors++; $display("FAIL m3_rx_data: got %h expected c3", f_rx); end
        n_checks++; if (f_mosi_bad !== 1'b0) begin n_errors++; $display("FAIL m3_mosi_edge: got %b expected 0", f_mosi_bad); end
        n_checks++; if (f_rises != 8) begin n_errors++; $display("FAIL m3_rises: got %0d expected 8", f_rises); end
        n_checks++; if (sl_rx !== 8'h3C) begin n_errors++; $display("FAIL m3_slave_rx: got %h expected 3c", sl_rx); end
    endtask

    task automatic test_lsb_first();
        loopback = 1'b0; sl_cpol = 1'b0; sl_cpha = 1'b1; sl_lsb = 1'b1; sl_tx = 8'h80;
        do_frame(1'b0, 1'b1, 1'b1, 8'd1, 2'd1, 8'h01, -1);
        n_checks++; if (f_got !== 1'b1) begin n_errors++; $display("FAIL lsb_rx_valid: got %b expected 1", f_got); end
        n_checks++; if (f_lat != 36) begin n_errors++; $display("FAIL lsb_latency: got %0d expected 36", f_lat); end
        n_checks++; if (f_rx !== 8'h80) begin n_errors++; $display("FAIL lsb_rx_data: got %h expected 80", f_rx); end
        n_checks++; if (sl_seq !== 8'h01) begin n_errors++; $display("FAIL lsb_mosi_order: got %b expected 00000001", sl_seq); end
        n_checks++; if (f_rises != 8) begin n_errors++; $display("FAIL lsb_rises: got %0d expected 8", f_rises); end
    endtask

    task automatic test_start_ignored();
        int extra_valid;
        int ready_low;
        loopback = 1'b1;
        do_frame(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'h96, 10);
        n_checks++; if (f_got !== 1'b1) begin n_errors++; $display("FAIL ign_rx_valid: got %b expected 1", f_got); end
        n_checks++; if (f_lat != 36) begin n_errors++; $display("FAIL ign_latency: got %0d expected 36", f_lat); end
        n_checks++; if (f_rx !== 8'h96) begin n_errors++; $display("FAIL ign_rx_data: got %h expected 96", f_rx); end
        n_checks++; if (f_cs_and !== 4'b1110) begin n_errors++; $display("FAIL ign_cs: got %b expected 1110", f_cs_and); end
        n_checks++; if (f_rdy_bad !== 1'b0) begin n_errors++; $display("FAIL ign_ready_busy: got %b expected 0", f_rdy_bad); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL ign_ready_after: got %b expected 1", ready); end
        extra_valid = 0;
        ready_low = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid === 1'b1) extra_valid++;
            if (ready !== 1'b1) ready_low++;
        end
        n_checks++; if (extra_valid != 0) begin n_errors++; $display("FAIL ign_extra_valid: got %0d expected 0", extra_valid); end
        n_checks++; if (ready_low != 0) begin n_errors++; $display("FAIL ign_queued_start: got %0d busy cycles expected 0", ready_low); end
    endtask

    task automatic test_reset_abort();
        int stray;
        loopback = 1'b1;
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; cs_sel = 2'd1;
        tx_data = 8'hF0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (spi_cs_n !== 4'b1101) begin n_errors++; $display("FAIL abort_cs_mid: got %b expected 1101", spi_cs_n); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL abort_ready_mid: got %b expected 0", ready); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (spi_cs_n !== 4'hF) begin n_errors++; $display("FAIL abort_cs: got %b expected 1111", spi_cs_n); end
        n_checks++; if (spi_sclk !== 1'b0) begin n_errors++; $display("FAIL abort_sclk: got %b expected 0", spi_sclk); end
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL abort_ready: got %b expected 1", ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL abort_rx_valid: got %b expected 0", rx_valid); end
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid === 1'b1) stray++;
        end
        n_checks++; if (stray != 0) begin n_errors++; $display("FAIL abort_stray_valid: got %0d expected 0", stray); end
        do_frame(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'h5A, -1);
        n_checks++; if (f_got !== 1'b1) begin n_errors++; $display("FAIL post_abort_valid: got %b expected 1", f_got); end
        n_checks++; if (f_rx !== 8'h5A) begin n_errors++; $display("FAIL post_abort_rx: got %h expected 5a", f_rx); end
        n_checks++; if (f_lat != 18) begin n_errors++; $display("FAIL post_abort_latency: got %0d expected 18", f_lat); end
        n_checks++; if (f_cs_and !== 4'b0111) begin n_errors++; $display("FAIL post_abort_cs: got %b expected 0111", f_cs_and); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int gap;
        int lat1;
        int lat2;
        logic [7:0] rx1;
        logic [7:0] rx2;
        bit restarted;
        pulses = 0; gap = 0; lat1 = 0; lat2 = 0; rx1 = 8'h00; rx2 = 8'h00; restarted = 1'b0;
        loopback = 1'b1;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; cs_sel = 2'd0;
        tx_data = 8'h3C; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hC5;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 20) start = 1'b0;
            if (rx_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin lat1 = k; rx1 = rx_data; end
                if (pulses == 2) begin lat2 = k; rx2 = rx_data; end
            end
            if (pulses == 1 && !restarted) begin
                if (spi_cs_n === 4'hF) gap++; else restarted = 1'b1;
            end
        end
        start = 1'b0;
        n_checks++; if (pulses != 2) begin n_errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        n_checks++; if (rx1 !== 8'h3C) begin n_errors++; $display("FAIL b2b_rx1: got %h expected 3c", rx1); end
        n_checks++; if (lat1 != 18) begin n_errors++; $display("FAIL b2b_lat1: got %0d expected 18", lat1); end
        n_checks++; if (rx2 !== 8'hC5) begin n_errors++; $display("FAIL b2b_rx2: got %h expected c5", rx2); end
        n_checks++; if (lat2 != 38) begin n_errors++; $display("FAIL b2b_lat2: got %0d expected 38", lat2); end
        n_checks++; if (gap != 2) begin n_errors++; $display("FAIL b2b_cs_gap: got %0d expected 2", gap); end
    endtask

    task automatic test_bad_cs();
        int togs;
        int cs_low;
        int lat;
        logic prev_sclk;
        logic [7:0] rxd;
        togs = 0; cs_low = 0; lat = 0; rxd = 8'h00;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        b_cs_sel = 3'd5; b_tx_data = 8'h69; b_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        prev_sclk = b_sclk;
        if (b_cs_n !== 5'h1F) cs_low++;
        n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL badcs_accept: got ready %b expected 0", b_ready); end
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_cs_n !== 5'h1F) cs_low++;
            if (b_rx_valid === 1'b1) begin lat = k; rxd = b_rx_data; break; end
            if (b_sclk !== prev_sclk) togs++;
            prev_sclk = b_sclk;
        end
        n_checks++; if (cs_low != 0) begin n_errors++; $display("FAIL badcs_cs_n: got %0d active cycles expected 0", cs_low); end
        n_checks++; if (togs != 16) begin n_errors++; $display("FAIL badcs_toggles: got %0d expected 16", togs); end
        n_checks++; if (lat != 18) begin n_errors++; $display("FAIL badcs_latency: got %0d expected 18", lat); end
        n_checks++; if (rxd !== 8'h69) begin n_errors++; $display("FAIL badcs_rx: got %h expected 69", rxd); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_lsb_first();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_bad_cs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
